data_mem_responder: RTL and testbench

//   Data-memory responder on the load/store side of the RV32I core. Accepts one request
//   per handshake (mem_read / mem_write, driven by the control unit's MemRead / MemWrite).

---
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store data-memory responder for an RV32I core: one request per handshake,
// byte/half/word access on an internal word array, one response pulse per request.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;

  // Request fields captured at the handshake edge
  logic          is_write_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        handshake;
  logic        req_err;
  logic        last_busy;
  logic [31:0] word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] store_lanes;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign handshake = req_valid & req_ready;
  assign last_busy = (state == BUSY) && (count == CW'(WAIT_CYCLES - 1));

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    req_err = 1'b0;
    if (mem_read == mem_write) req_err = 1'b1;
    if (mem_read && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) req_err = 1'b1;
    if (mem_write && funct3 > 3'b010) req_err = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0]) req_err = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) req_err = 1'b1;
    if (addr[31:2] >= DEPTH_LIM) req_err = 1'b1;
  end

  assign word = mem[widx_q];

  always_comb begin
    case (lane_q)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = lane_q[1] ? word[31:16] : word[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = word;
    endcase
  end

  // Narrow stores replicate their data across lanes; byte_en picks the live ones
  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        byte_en[lane_q] = 1'b1;
        store_lanes     = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en     = lane_q[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{wdata_q[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (handshake) begin
            if (req_err) begin
              state     <= RESP;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (last_busy) begin
            state     <= RESP;
            rsp_err   <= 1'b0;
            rsp_rdata <= is_write_q ? 32'd0 : load_data;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      is_write_q <= mem_write;
      f3_q       <= funct3;
      lane_q     <= addr[1:0];
      widx_q     <= addr[AW+1:2];
      wdata_q    <= wdata;
    end
  end

  // NOTE: the memory array has no reset; a reset only blocks an in-flight store.
  always_ff @(posedge clk) begin
    if (!rst && last_busy && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx_q][8*i +: 8] <= store_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a byte-level memory model predicts every
// response and one compare process checks the response outputs each cycle.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  mb [4*DEPTH];
  bit          exp_pending = 1'b0;
  int          exp_due;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] held = 32'd0;
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Byte-addressed reference: stores write bytes, loads gather and extend them
  task automatic model_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic err, output logic [31:0] data);
    int size;
    longint v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err  = 1'b0;
    data = 32'd0;
    if (rd == wr) err = 1'b1;
    if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) err = 1'b1;
    if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) err = 1'b1;
    if ((a % size) != 0) err = 1'b1;
    if ((a >> 2) >= DEPTH) err = 1'b1;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(mb[a + i]) << (8 * i));
      if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
        v = v - (longint'(1) << (8 * size));
      data = v[31:0];
    end
  endtask

  // Compare process: response outputs are checked on every falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      held = 32'd0;
    end else if (exp_pending && cyc == exp_due) begin
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      got_rdata   = rsp_rdata;
      got_err     = rsp_err;
      held        = exp_rdata;
      exp_pending = 1'b0;
    end else begin
      check("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
      check("rsp_rdata_hold", rsp_rdata, held);
    end
  end

  // mode 0: normal, 1: hold req_valid and wiggle inputs while busy, 2: reset while busy
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int mode,
                       input bit lit, input logic [31:0] lit_data, input logic lit_err);
    int k;
    int hs;
    int lat;
    logic e;
    logic [31:0] d;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    hs = cyc;
    if (mode == 2) begin
      #1;
      rst = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("ready_after_abort", {31'd0, req_ready}, 32'd1);
      return;
    end
    model_req(rd, wr, f3, a, wd, e, d);
    lat         = e ? 1 : WAIT + 1;
    exp_err     = e;
    exp_rdata   = d;
    exp_due     = hs + lat;
    exp_pending = 1'b1;
    #1;
    if (mode == 1) begin
      for (int i = 0; i < lat; i++) begin
        check("ready_while_busy", {31'd0, req_ready}, 32'd0);
        if (i == lat - 1) req_valid = 1'b0;
        else begin
          addr = addr + 32'd4; wdata = ~wdata; mem_write = ~mem_write; mem_read = ~mem_read;
        end
        @(posedge clk); #1;
      end
    end else begin
      req_valid = 1'b0;
    end
    k = 0;
    while (exp_pending && k < 30) begin
      @(posedge clk); #1; k++;
    end
    if (exp_pending) begin
      check("rsp_timeout", 32'd0, 32'd1);
      exp_pending = 1'b0;
    end else if (lit) begin
      check("lit_rdata", got_rdata, lit_data);
      check("lit_err", {31'd0, got_err}, {31'd0, lit_err});
    end
  endtask

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // word store/load
    issue(0, 1, W, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    issue(1, 0, W, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    // byte store, signed/unsigned byte loads, lane preservation
    issue(0, 1, B, 32'h13, 32'h00000080, 0, 0, 32'h0, 0);
    issue(1, 0, B, 32'h13, 32'h0, 0, 1, 32'hFFFFFF80, 0);
    issue(1, 0, BU, 32'h13, 32'h0, 0, 1, 32'h00000080, 0);
    issue(1, 0, W, 32'h10, 32'h0, 0, 1, 32'h80ADBEEF, 0);
    // halfword store and loads, misaligned half
    issue(0, 1, H, 32'h12, 32'h00001234, 0, 0, 32'h0, 0);
    issue(1, 0, H, 32'h12, 32'h0, 0, 1, 32'h00001234, 0);
    issue(1, 0, H, 32'h11, 32'h0, 0, 1, 32'h0, 1);
    issue(1, 0, H, 32'h10, 32'h0, 0, 1, 32'hFFFFBEEF, 0);
    issue(1, 0, HU, 32'h10, 32'h0, 0, 1, 32'h0000BEEF, 0);
    // error paths leave memory untouched
    issue(0, 1, W, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0, 0);
    issue(0, 1, W, 32'h21, 32'h12345678, 0, 1, 32'h0, 1);
    issue(1, 0, W, 32'h20, 32'h0, 0, 1, 32'hCAFEF00D, 0);
    issue(1, 1, W, 32'h20, 32'h0, 0, 1, 32'h0, 1);
    issue(0, 0, W, 32'h20, 32'h0, 0, 1, 32'h0, 1);
    issue(1, 0, W, 32'd4 * DEPTH, 32'h0, 0, 1, 32'h0, 1);
    issue(1, 0, 3'b011, 32'h20, 32'h0, 0, 1, 32'h0, 1);
    issue(0, 1, 3'b100, 32'h20, 32'h0, 0, 1, 32'h0, 1);
    // last legal byte address
    issue(0, 1, B, 32'd4 * DEPTH - 1, 32'h0000005A, 0, 0, 32'h0, 0);
    issue(1, 0, BU, 32'd4 * DEPTH - 1, 32'h0, 0, 1, 32'h0000005A, 0);
    // inputs changing while busy are ignored
    issue(1, 0, W, 32'h10, 32'h0, 1, 1, 32'h1234BEEF, 0);
    // reset while busy aborts the store
    issue(0, 1, W, 32'h30, 32'h11111111, 0, 0, 32'h0, 0);
    issue(0, 1, W, 32'h30, 32'h22222222, 2, 0, 32'h0, 0);
    issue(1, 0, W, 32'h30, 32'h0, 0, 1, 32'h11111111, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
